// File: rtl/hazard_issue_buffer.sv
// hazard_issue_buffer: a small in-order micro-op FIFO that sits between decode and
// operand fetch.
// For the head entry it publishes a read mask and a write mask to the hazard controller.
// The controller can answer with a bubble, in which case the head stays in place.
// Optional macro HIB_STALL_CNT_EN adds a saturating 16-bit stall_cnt output. It counts
// cycles in which the buffer holds an entry that the controller is bubbling.
module hazard_issue_buffer #(
  parameter int DEPTH = 4,
  parameter int UOP_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_src1,
  input  logic [3:0]       in_src2,
  input  logic [3:0]       in_dst,
  input  logic             in_src1_used,
  input  logic             in_src2_used,
  input  logic             in_dst_used,
  input  logic [UOP_W-1:0] in_uop,
  output logic [15:0]      id_out_req,
  output logic [15:0]      id_out_prov,
  input  logic             cl_out_nop_id,
  input  logic             flush,
  output logic             of_valid,
  output logic [UOP_W-1:0] of_uop,
  input  logic             of_ready
`ifdef HIB_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Entry storage. The head is read combinationally so that it is visible one cycle after a push.
  logic [UOP_W-1:0] uop_mem  [DEPTH];
  logic [3:0]       src1_mem [DEPTH];
  logic [3:0]       src2_mem [DEPTH];
  logic [3:0]       dst_mem  [DEPTH];
  logic             src1_used_mem [DEPTH];
  logic             src2_used_mem [DEPTH];
  logic             dst_used_mem  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;

  logic head_valid;
  logic push, pop;
  logic [15:0] req_bits, prov_bits;

  // reset is folded into the handshakes so that nothing moves or shows while it is low.
  assign head_valid = reset && (count_reg != '0);
  assign in_ready   = reset && (count_reg < DEPTH_C) && !flush;
  assign of_valid   = head_valid && !cl_out_nop_id && !flush;
  assign push       = in_valid && in_ready;
  assign pop        = of_valid && of_ready;
  assign of_uop     = head_valid ? uop_mem[rd_ptr_reg] : '0;

  // One-hot decode of the head indices. src1 == src2 naturally collapses to one bit.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_mask
      assign req_bits[gi]  = (src1_used_mem[rd_ptr_reg] && (src1_mem[rd_ptr_reg] == 4'(gi))) ||
                             (src2_used_mem[rd_ptr_reg] && (src2_mem[rd_ptr_reg] == 4'(gi)));
      assign prov_bits[gi] = dst_used_mem[rd_ptr_reg] && (dst_mem[rd_ptr_reg] == 4'(gi));
    end
  endgenerate

  assign id_out_req  = head_valid ? req_bits  : 16'h0000;
  assign id_out_prov = head_valid ? prov_bits : 16'h0000;

  // Occupancy after this cycle's push and pop. When both happen, the occupancy is unchanged.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointer and occupancy registers. Reset outranks flush, and flush outranks push and pop.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
    end
  end

  // Write an accepted micro-op into the tail slot. Contents are never cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      uop_mem[wr_ptr_reg]       <= in_uop;
      src1_mem[wr_ptr_reg]      <= in_src1;
      src2_mem[wr_ptr_reg]      <= in_src2;
      dst_mem[wr_ptr_reg]       <= in_dst;
      src1_used_mem[wr_ptr_reg] <= in_src1_used;
      src2_used_mem[wr_ptr_reg] <= in_src2_used;
      dst_used_mem[wr_ptr_reg]  <= in_dst_used;
    end
  end

`ifdef HIB_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;

  // Count cycles in which an occupied buffer is bubbled. The count saturates and is cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset)
      stall_cnt_reg <= 16'h0000;
    else if ((count_reg != '0) && cl_out_nop_id && (stall_cnt_reg != 16'hFFFF))
      stall_cnt_reg <= stall_cnt_reg + 16'h0001;
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_issue_buffer.sv
// Testbench for hazard_issue_buffer.
// The reference model is a queue of entries plus the handshake rules. Directed scenarios
// run first, followed by randomized traffic. Build with HIB_STALL_CNT_EN to also check
// stall_cnt.
module tb_hazard_issue_buffer;

  localparam int DEPTH = 4;
  localparam int UOP_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready;
  logic [3:0]       in_src1, in_src2, in_dst;
  logic             in_src1_used, in_src2_used, in_dst_used;
  logic [UOP_W-1:0] in_uop;
  logic [15:0]      id_out_req, id_out_prov;
  logic             cl_out_nop_id, flush, of_valid, of_ready;
  logic [UOP_W-1:0] of_uop;
`ifdef HIB_STALL_CNT_EN
  logic [15:0]      stall_cnt;
`endif

  hazard_issue_buffer #(.DEPTH(DEPTH), .UOP_W(UOP_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_src1(in_src1), .in_src2(in_src2), .in_dst(in_dst),
    .in_src1_used(in_src1_used), .in_src2_used(in_src2_used), .in_dst_used(in_dst_used),
    .in_uop(in_uop), .id_out_req(id_out_req), .id_out_prov(id_out_prov),
    .cl_out_nop_id(cl_out_nop_id), .flush(flush), .of_valid(of_valid),
    .of_uop(of_uop), .of_ready(of_ready)
`ifdef HIB_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [UOP_W-1:0] uop;
    logic [3:0] s1, s2, d;
    logic u1, u2, ud;
  } ent_t;

  ent_t q[$];
  int unsigned stall_m;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end else
      $display("ok   %s: 0x%0h at %0t", tag, got, $time);
  endtask

  function automatic logic [15:0] req_of(input ent_t e);
    logic [15:0] r;
    r = 16'h0;
    if (e.u1) r[e.s1] = 1'b1;
    if (e.u2) r[e.s2] = 1'b1;
    return r;
  endfunction

  function automatic logic [15:0] prov_of(input ent_t e);
    logic [15:0] r;
    r = 16'h0;
    if (e.ud) r[e.d] = 1'b1;
    return r;
  endfunction

  // Expected handshake values derived from the model and the current inputs.
  function automatic logic exp_in_ready();
    return reset && (q.size() < DEPTH) && !flush;
  endfunction

  function automatic logic exp_of_valid();
    return reset && (q.size() != 0) && !cl_out_nop_id && !flush;
  endfunction

  // Apply inputs shortly after a posedge, then compare every output at the following negedge.
  task automatic drive(input logic rst, input logic iv, input logic fl, input logic nop,
                       input logic ordy, input logic [3:0] s1, input logic [3:0] s2,
                       input logic [3:0] d, input logic u1, input logic u2, input logic ud,
                       input logic [UOP_W-1:0] uop);
    reset = rst; in_valid = iv; flush = fl; cl_out_nop_id = nop; of_ready = ordy;
    in_src1 = s1; in_src2 = s2; in_dst = d;
    in_src1_used = u1; in_src2_used = u2; in_dst_used = ud; in_uop = uop;
    #4;
    check("in_ready", 64'(in_ready), 64'(exp_in_ready()));
    check("of_valid", 64'(of_valid), 64'(exp_of_valid()));
    if (reset && q.size() != 0) begin
      check("id_out_req", 64'(id_out_req), 64'(req_of(q[0])));
      check("id_out_prov", 64'(id_out_prov), 64'(prov_of(q[0])));
      check("of_uop", 64'(of_uop), 64'(q[0].uop));
    end else begin
      check("id_out_req", 64'(id_out_req), 64'h0);
      check("id_out_prov", 64'(id_out_prov), 64'h0);
      check("of_uop", 64'(of_uop), 64'h0);
    end
`ifdef HIB_STALL_CNT_EN
    check("stall_cnt", 64'(stall_cnt), 64'(stall_m));
`endif
  endtask

  task automatic idle(input logic ordy, input logic nop);
    drive(1'b1, 1'b0, 1'b0, nop, ordy, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic push_uop(input logic ordy, input logic [3:0] s1, input logic [3:0] s2,
                          input logic [3:0] d, input logic u1, input logic u2,
                          input logic ud, input logic [UOP_W-1:0] uop);
    drive(1'b1, 1'b1, 1'b0, 1'b0, ordy, s1, s2, d, u1, u2, ud, uop);
  endtask

  // Advance the model with the decisions of this cycle, then move to the next cycle.
  task automatic tick();
    logic do_pop, do_push;
    ent_t e;
    do_pop  = exp_of_valid() && of_ready;
    do_push = in_valid && exp_in_ready();
    if (!reset) stall_m = 0;
    else if (q.size() != 0 && cl_out_nop_id && stall_m < 32'hFFFF) stall_m++;
    if (!reset || flush) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.uop = in_uop; e.s1 = in_src1; e.s2 = in_src2; e.d = in_dst;
        e.u1 = in_src1_used; e.u2 = in_src2_used; e.ud = in_dst_used;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    stall_m = 0;
    @(posedge clk); #1;

    // Reset: outputs quiet and in_ready low while held, in_ready high right after release.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b1, 32'hDEAD);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    idle(1'b0, 1'b0);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_of_valid", 64'(of_valid), 64'd0);
    tick();

    // Single entry with src 3 and 5 and dst 7, issued the cycle after it is pushed.
    push_uop(1'b1, 4'd3, 4'd5, 4'd7, 1'b1, 1'b1, 1'b1, 32'hA1);
    check("empty_no_bypass", 64'(of_valid), 64'd0);
    tick();
    idle(1'b1, 1'b0);
    check("single_of_valid", 64'(of_valid), 64'd1);
    check("single_req", 64'(id_out_req), 64'h0028);
    check("single_prov", 64'(id_out_prov), 64'h0080);
    check("single_uop", 64'(of_uop), 64'hA1);
    tick();
    idle(1'b1, 1'b0);
    check("single_drained", 64'(of_valid), 64'd0);
    tick();

    // Mask corner cases: an unused source, and both sources naming the same register.
    push_uop(1'b0, 4'd9, 4'd4, 4'd6, 1'b0, 1'b1, 1'b0, 32'hB0);
    tick();
    push_uop(1'b0, 4'd2, 4'd2, 4'd1, 1'b1, 1'b1, 1'b1, 32'hB1);
    tick();
    idle(1'b1, 1'b0);
    check("unused_src_req", 64'(id_out_req), 64'h0010);
    check("unused_dst_prov", 64'(id_out_prov), 64'h0000);
    tick();
    idle(1'b1, 1'b0);
    check("same_src_req", 64'(id_out_req), 64'h0004);
    tick();

    // Fill to DEPTH, refuse a push while full even when popping, then drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      push_uop(1'b0, 4'(i), 4'(i + 1), 4'(i + 2), 1'b1, 1'b0, 1'b1, 32'hC0 + 32'(i));
      tick();
    end
    idle(1'b0, 1'b0);
    check("full_in_ready", 64'(in_ready), 64'd0);
    tick();
    push_uop(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 32'hC4);
    check("full_pop_no_push", 64'(in_ready), 64'd0);
    check("full_head", 64'(of_uop), 64'hC0);
    tick();
    for (int i = 1; i < DEPTH; i++) begin
      idle(1'b1, 1'b0);
      check("drain_order", 64'(of_uop), 64'hC0 + 64'(i));
      tick();
    end
    idle(1'b1, 1'b0);
    check("drained_empty", 64'(of_valid), 64'd0);
    tick();

    // Three bubble cycles hold the head and its masks in place.
    push_uop(1'b0, 4'd8, 4'd15, 4'd0, 1'b1, 1'b1, 1'b1, 32'hD0);
    tick();
    for (int i = 0; i < 3; i++) begin
      idle(1'b1, 1'b1);
      check("bubble_of_valid", 64'(of_valid), 64'd0);
      check("bubble_req", 64'(id_out_req), 64'h8100);
      check("bubble_prov", 64'(id_out_prov), 64'h0001);
      tick();
    end
    idle(1'b1, 1'b0);
`ifdef HIB_STALL_CNT_EN
    check("stall_cnt_3", 64'(stall_cnt), 64'd3);
`endif
    check("bubble_head_kept", 64'(of_uop), 64'hD0);
    tick();

    // A flush with three entries buffered also discards the push offered in the same cycle.
    for (int i = 0; i < 3; i++) begin
      push_uop(1'b0, 4'(i), 4'(i), 4'(i), 1'b1, 1'b1, 1'b1, 32'hE0 + 32'(i));
      tick();
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 4'd5, 4'd5, 1'b1, 1'b1, 1'b1, 32'hE9);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    check("flush_of_valid", 64'(of_valid), 64'd0);
    tick();
    idle(1'b1, 1'b0);
    check("flushed_of_valid", 64'(of_valid), 64'd0);
    check("flushed_req", 64'(id_out_req), 64'h0);
    check("flushed_prov", 64'(id_out_prov), 64'h0);
    tick();

    // Reset arriving during a simultaneous push and pop with two entries buffered.
    for (int i = 0; i < 2; i++) begin
      push_uop(1'b0, 4'd1, 4'd1, 4'd1, 1'b1, 1'b0, 1'b1, 32'hF0 + 32'(i));
      tick();
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 4'd3, 4'd3, 1'b1, 1'b1, 1'b1, 32'hF9);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, '0);
    check("held_rst_in_ready", 64'(in_ready), 64'd0);
    tick();
    idle(1'b1, 1'b0);
    check("rel_in_ready", 64'(in_ready), 64'd1);
    check("rel_empty", 64'(of_valid), 64'd0);
    tick();

    // Randomized traffic checked cycle by cycle against the queue model.
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 24) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) != 0), 4'($urandom), 4'($urandom), 4'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 32'($urandom));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
